// File: rtl/img_data_mem.sv
// img_data_mem: image data memory with streaming LOAD/DUMP ports and a
// single-cycle-latency core data port. A single write port and a single
// synchronous read port are shared between the host streams and the core.
module img_data_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  input  logic [ADDR_W-1:0] addr,
  input  logic              write,
  input  logic              read,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dump_start,
  input  logic [ADDR_W:0]   dump_len,
  output logic              dump_valid,
  output logic [DATA_W-1:0] dump_data,
  input  logic              dump_ready,
  output logic              dump_done,
  output logic              busy
);

  localparam int              DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LEN_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] LEN_ZERO  = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DUMP = 2'd3
  } state_t;

  // Lengths larger than the array are clipped so a transfer never wraps.
  function automatic logic [ADDR_W:0] clip_len(input logic [ADDR_W:0] len);
    return (len > DEPTH_LEN) ? DEPTH_LEN : len;
  endfunction

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   len_q;      // latched, clipped transfer length
  logic [ADDR_W:0]   cnt_q;      // LOAD: words written; DUMP: reads issued
  logic [ADDR_W:0]   tx_q;       // DUMP: beats accepted by the host
  logic [ADDR_W:0]   ld_len_c;
  logic [ADDR_W:0]   dump_len_c;

  logic              ld_go, dump_go, ld_fin, dump_fin;
  logic              ld_hs, dump_xfer, run_rd;
  logic              out_adv, p0_adv, issue;

  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_waddr, mem_raddr;
  logic [DATA_W-1:0] mem_wdata;

  // Stage p0: synchronous RAM read register, shared by core reads and dump
  logic [DATA_W-1:0] rd_data_p0;
  logic              vld_p0;

  assign ld_len_c   = clip_len(ld_len);
  assign dump_len_c = clip_len(dump_len);

  assign ld_ready   = (state_q == S_LOAD);
  assign busy       = (state_q != S_RUN);
  assign dout       = rd_data_p0;

  assign ld_hs      = (state_q == S_LOAD) && ld_valid;
  assign dump_xfer  = dump_valid && dump_ready;
  assign run_rd     = (state_q == S_RUN) && read;

  // The dump pipeline advances when the output slot is empty or draining;
  // stage p0 may accept a new read when it is empty or moves forward.
  assign out_adv    = !dump_valid || dump_ready;
  assign p0_adv     = !vld_p0 || out_adv;
  assign issue      = (state_q == S_DUMP) && (cnt_q != len_q) && p0_adv;

  // Next-state and transfer-start/finish decode
  always_comb begin
    state_d  = state_q;
    ld_go    = 1'b0;
    dump_go  = 1'b0;
    ld_fin   = 1'b0;
    dump_fin = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ld_start) ld_go = 1'b1;
      end
      S_LOAD: begin
        if (ld_hs && (cnt_q == len_q - LEN_ONE)) begin
          ld_fin  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (ld_start)        ld_go   = 1'b1;
        else if (dump_start) dump_go = 1'b1;
      end
      S_DUMP: begin
        if (dump_xfer && (tx_q == len_q - LEN_ONE)) begin
          dump_fin = 1'b1;
          state_d  = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A zero-length request finishes at once and never leaves RUN.
    if (ld_go) begin
      if (ld_len_c == LEN_ZERO) begin
        ld_fin  = 1'b1;
        state_d = S_RUN;
      end else begin
        state_d = S_LOAD;
      end
    end
    if (dump_go) begin
      if (dump_len_c == LEN_ZERO) begin
        dump_fin = 1'b1;
        state_d  = S_RUN;
      end else begin
        state_d  = S_DUMP;
      end
    end
  end

  // RAM port steering: LOAD streams into the array, RUN serves the core,
  // DUMP reads sequentially from address 0.
  always_comb begin
    mem_we    = ld_hs || ((state_q == S_RUN) && write);
    mem_waddr = addr;
    mem_wdata = din;
    if (state_q == S_LOAD) begin
      mem_waddr = cnt_q[ADDR_W-1:0];
      mem_wdata = ld_data;
    end
    mem_re    = run_rd || issue;
    mem_raddr = (state_q == S_DUMP) ? cnt_q[ADDR_W-1:0] : addr;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Length latch and word/beat counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
      cnt_q <= '0;
      tx_q  <= '0;
    end else if (ld_go || dump_go) begin
      len_q <= ld_go ? ld_len_c : dump_len_c;
      cnt_q <= '0;
      tx_q  <= '0;
    end else begin
      if (ld_hs || issue) cnt_q <= cnt_q + LEN_ONE;
      if (dump_xfer)      tx_q  <= tx_q + LEN_ONE;
    end
  end

  // Memory array write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Stage p0: read-before-write, so a same-address read sees the old word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_p0 <= '0;
      vld_p0     <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      if (mem_re) rd_data_p0 <= mem[mem_raddr];
      if (issue)       vld_p0 <= 1'b1;
      else if (p0_adv) vld_p0 <= 1'b0;
      dout_valid <= run_rd;
    end
  end

  // Stage p1: dump output register, holds its beat while the host stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dump_valid <= 1'b0;
      dump_data  <= '0;
    end else if (out_adv) begin
      dump_valid <= vld_p0;
      if (vld_p0) dump_data <= rd_data_p0;
    end
  end

  // One-cycle completion pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_done   <= 1'b0;
      dump_done <= 1'b0;
    end else begin
      ld_done   <= ld_fin;
      dump_done <= dump_fin;
    end
  end

endmodule

// File: doc/img_data_mem.md
# img_data_mem

Parametrised data memory for the image-downsampling processor. It replaces file-based image load and store with streaming handshake ports: the host streams the image in (LOAD), the processor core reads and writes the image through its data port (RUN), and the host streams the result out (DUMP). It sits between the host/UART bridge and the core's load/store unit.

## Interface
Parameters:
- DATA_W, 8, word width in bits
- ADDR_W, 16, address width; DEPTH = 2**ADDR_W words

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ld_start  in  1  start LOAD; accepted in IDLE or RUN
- ld_len  in  ADDR_W+1  words to load; latched on ld_start
- ld_valid  in  1  host load beat valid
- ld_data  in  DATA_W  host load data
- ld_ready  out  1  memory accepts a load beat
- ld_done  out  1  one-cycle pulse when LOAD completes
- addr  in  ADDR_W  core address
- write  in  1  core write strobe
- read  in  1  core read strobe
- din  in  DATA_W  core write data
- dout  out  DATA_W  core read data, registered
- dout_valid  out  1  dout updated this cycle
- dump_start  in  1  start DUMP; accepted in RUN only
- dump_len  in  ADDR_W+1  words to dump from address 0; latched on dump_start
- dump_valid  out  1  dump beat valid
- dump_data  out  DATA_W  dump data
- dump_ready  in  1  host accepts a dump beat
- dump_done  out  1  one-cycle pulse after the last dump beat is accepted
- busy  out  1  high whenever state is not RUN

## Operation
- States: IDLE, LOAD, RUN, DUMP. Reset enters IDLE.
- IDLE: ld_start -> LOAD. All other inputs are ignored.
- LOAD: word counter cleared on entry; ld_ready=1. Each ld_valid&&ld_ready writes RAM[cnt]=ld_data and increments cnt. When cnt reaches the latched length: ld_done pulses, ld_ready drops, state -> RUN.
- RUN:
  - write: RAM[addr]=din.
  - read: dout=RAM[addr] next cycle, with dout_valid=1 for that cycle.
  - read and write to the same address in the same cycle: read returns the old data.
  - dump_start -> DUMP; a read/write in the same cycle still executes.
  - ld_start -> LOAD (reload); a same-cycle read/write still executes.
  - dump_start and ld_start together: ld_start wins.
- DUMP: reads addresses 0..len-1 in order and presents them on dump_data/dump_valid. A beat transfers on dump_valid&&dump_ready. After the last transfer, dump_done pulses and state -> RUN.
- read/write/din in IDLE, LOAD or DUMP: ignored; memory unchanged; dout_valid stays 0.
- Length rules: latched lengths above DEPTH are clipped to DEPTH. Length 0 completes immediately: the done pulse comes the cycle after start, with no beats transferred.
- Counter is ADDR_W+1 bits, so a full-DEPTH transfer terminates without wrapping to address 0.
- Memory contents are not reset. Reset only clears state, counters and outputs. Contents survive reset and reload, except the words a reload overwrites.

## Timing
- Reset values: ld_ready=0, ld_done=0, dout=0, dout_valid=0, dump_valid=0, dump_data=0, dump_done=0, busy=1.
- Reset asserted mid-LOAD or mid-DUMP aborts immediately: outputs go to reset values, state goes to IDLE, and no done pulse is issued.
- LOAD:
  - ld_ready rises the cycle after ld_start is sampled.
  - The write occurs on the handshake edge.
  - ld_done=1 and busy=0 in the cycle after the final beat's edge.
- RUN read latency: 1 cycle (read sampled at edge N; dout/dout_valid valid after edge N+1). Back-to-back reads sustain 1 per cycle.
- DUMP:
  - First dump_valid is high 2 cycles after dump_start is sampled (synchronous RAM read).
  - While dump_valid=1 and dump_ready=0, dump_data holds stable.
  - With dump_ready held high, throughput is 1 beat per cycle (prefetch/skid register required).
  - dump_valid drops the cycle after the last transfer; dump_done pulses in that same cycle.
- ld_done and dump_done are exactly one cycle wide.

## Test plan
- LOAD ld_len=4 with beats 0x11,0x22,0x33,0x44 and one idle ld_valid gap -> RAM[0..3] hold those values; ld_done one cycle after the 4th beat; busy 1->0 in that cycle.
- RUN write 0xA5 @0x0010, then read 0x0010 -> dout=0xA5 with dout_valid one cycle later. Same-cycle write 0x5A plus read @0x0010 -> dout=0xA5; a later read -> 0x5A.
- DUMP dump_len=4 after the load above, dump_ready pattern 1,0,0,1,1,1 -> beats 0x11,0x22,0x33,0x44 in order; data stable during stalls; dump_done after the 4th transfer; busy=0 afterwards.
- ld_len=0 and dump_len=0 -> done pulse one cycle after start, no ld_ready/dump_valid activity, memory unchanged.
- write/read strobes during LOAD and DUMP -> no memory change, dout_valid=0. dump_start in IDLE -> ignored.
- rst_n pulled low mid-DUMP (after 2 beats) -> all outputs at reset values, state IDLE, no dump_done. Then reload with ld_len=2 (0x77,0x88) and dump 4 -> 0x77,0x88,0x33,0x44.
